// File: rtl/core_dbg_ctrl_if.sv
// -----------------------------------------------------------------------------
// core_dbg_ctrl_if
// Core-side debug register access bus between the debug APB slave (master)
// and core_dbg_ctrl (slave).
//   dbg_req       master->slave  single-cycle access request
//   dbg_wr_rd     master->slave  1 = write, 0 = read
//   dbg_addr      master->slave  register word address
//   dbg_wdata     master->slave  write data
//   dbg_wstrobe   master->slave  byte enables (scratch registers only)
//   dbg_rdata     slave->master  read data, held until the next read
//   dbg_rd_ready  slave->master  read data valid pulse
//   dbg_err       slave->master  access error pulse
// -----------------------------------------------------------------------------
interface core_dbg_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
);
    logic                      dbg_req;
    logic                      dbg_wr_rd;
    logic [REG_ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0]     dbg_wdata;
    logic [DATA_WIDTH/8-1:0]   dbg_wstrobe;
    logic [DATA_WIDTH-1:0]     dbg_rdata;
    logic                      dbg_rd_ready;
    logic                      dbg_err;

    modport master (
        output dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata, dbg_wstrobe,
        input  dbg_rdata, dbg_rd_ready, dbg_err
    );

    modport slave (
        input  dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata, dbg_wstrobe,
        output dbg_rdata, dbg_rd_ready, dbg_err
    );
endinterface

// File: rtl/core_dbg_ctrl.sv
// -----------------------------------------------------------------------------
// core_dbg_ctrl
// Core debug unit: decoded register map, byte-strobed scratch registers,
// halt/resume/single-step state machine, retired-instruction counter and
// last-retired-PC snapshot.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   dbg                 debug register bus (core_dbg_ctrl_if.slave)
//   core_retire_valid   one instruction retired this cycle
//   core_retire_addr    word address of the retired instruction
//   core_fetch_addr     current fetch word address (breakpoint compare)
//   core_pipe_empty     no instructions in flight
//   core_stall          fetch stall (HALTING or HALTED)
//   core_halted         state == HALTED
// Optional feature macro: CORE_DBG_BKPT_EN enables the breakpoint register
// (address 5) and the STATUS.bkpt_hit flag.
// -----------------------------------------------------------------------------
module core_dbg_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SCRATCH    = 8,
    parameter int CNT_WIDTH      = 48,
    parameter int RST_HALT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    core_dbg_ctrl_if.slave        dbg,
    input  logic                  core_retire_valid,
    input  logic [ADDR_WIDTH-3:0] core_retire_addr,
    input  logic [ADDR_WIDTH-3:0] core_fetch_addr,
    input  logic                  core_pipe_empty,
    output logic                  core_stall,
    output logic                  core_halted
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [REG_ADDR_WIDTH-1:0] A_CTRL = REG_ADDR_WIDTH'(0);
    localparam logic [REG_ADDR_WIDTH-1:0] A_STAT = REG_ADDR_WIDTH'(1);
    localparam logic [REG_ADDR_WIDTH-1:0] A_PC   = REG_ADDR_WIDTH'(2);
    localparam logic [REG_ADDR_WIDTH-1:0] A_CLO  = REG_ADDR_WIDTH'(3);
    localparam logic [REG_ADDR_WIDTH-1:0] A_CHI  = REG_ADDR_WIDTH'(4);
    localparam logic [REG_ADDR_WIDTH-1:0] A_BKPT = REG_ADDR_WIDTH'(5);
    localparam logic [REG_ADDR_WIDTH-1:0] A_LAST = REG_ADDR_WIDTH'(5 + NUM_SCRATCH);
`ifdef CORE_DBG_BKPT_EN
    localparam logic [REG_ADDR_WIDTH-1:0] A_RO_LAST = A_CHI;
`else
    // Without the breakpoint feature, address 5 behaves as read-only zero.
    localparam logic [REG_ADDR_WIDTH-1:0] A_RO_LAST = A_BKPT;
`endif

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTING = 2'd1,
        HALTED  = 2'd2,
        STEP    = 2'd3
    } state_t;

    localparam state_t RST_STATE = (RST_HALT != 0) ? HALTED : RUN;

    state_t                  state, state_nxt;
    logic                    bkpt_hit, bkpt_hit_nxt;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [ADDR_WIDTH-3:0]   pc;
    logic [DATA_WIDTH-1:0]   scratch [NUM_SCRATCH];
    logic [DATA_WIDTH-1:0]   rd_val;
    logic                    rd_req, wr_req, acc_err, addr_bad, ro_hit;
    logic                    halt_cmd, resume_cmd, step_cmd, clr_cmd;
    logic                    bkpt_match;

`ifdef CORE_DBG_BKPT_EN
    logic [DATA_WIDTH-1:0]   bkpt;
    assign bkpt_match = bkpt[0] && (core_fetch_addr == bkpt[ADDR_WIDTH-1:2]);
`else
    logic                    unused_fetch;
    assign unused_fetch = ^core_fetch_addr;
    assign bkpt_match   = 1'b0;
`endif

    assign rd_req   = dbg.dbg_req && !dbg.dbg_wr_rd;
    assign wr_req   = dbg.dbg_req &&  dbg.dbg_wr_rd;
    assign addr_bad = dbg.dbg_addr > A_LAST;
    assign ro_hit   = (dbg.dbg_addr >= A_STAT) && (dbg.dbg_addr <= A_RO_LAST);
    assign acc_err  = dbg.dbg_req && (addr_bad || (dbg.dbg_wr_rd && ro_hit));

    assign halt_cmd   = wr_req && (dbg.dbg_addr == A_CTRL) && dbg.dbg_wdata[0];
    assign resume_cmd = wr_req && (dbg.dbg_addr == A_CTRL) && dbg.dbg_wdata[1];
    assign step_cmd   = wr_req && (dbg.dbg_addr == A_CTRL) && dbg.dbg_wdata[2];
    assign clr_cmd    = wr_req && (dbg.dbg_addr == A_CTRL) && dbg.dbg_wdata[3];

    assign core_stall  = (state == HALTING) || (state == HALTED);
    assign core_halted = (state == HALTED);

    // Read mux; samples registers before this edge's updates.
    always_comb begin
        rd_val = '0;
        case (dbg.dbg_addr)
            A_STAT: rd_val = DATA_WIDTH'({bkpt_hit, state == HALTED, state});
            A_PC:   rd_val = DATA_WIDTH'({pc, 2'b00});
            A_CLO:  rd_val = cnt[DATA_WIDTH-1:0];
            A_CHI:  rd_val = DATA_WIDTH'(cnt >> DATA_WIDTH);
`ifdef CORE_DBG_BKPT_EN
            A_BKPT: rd_val = bkpt;
`endif
            default: begin
                for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                    if (dbg.dbg_addr == REG_ADDR_WIDTH'(6 + i)) rd_val = scratch[i];
                end
            end
        endcase
    end

    // HALT beats RESUME only in RUN; RESUME beats HALT/STEP when stalled.
    always_comb begin
        state_nxt    = state;
        bkpt_hit_nxt = bkpt_hit;
        case (state)
            RUN: begin
                if (halt_cmd) begin
                    state_nxt = HALTING;
                end else if (bkpt_match) begin
                    state_nxt    = HALTING;
                    bkpt_hit_nxt = 1'b1;
                end
            end
            HALTING: begin
                if (resume_cmd) begin
                    state_nxt    = RUN;
                    bkpt_hit_nxt = 1'b0;
                end else if (core_pipe_empty) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (resume_cmd) begin
                    state_nxt    = RUN;
                    bkpt_hit_nxt = 1'b0;
                end else if (step_cmd) begin
                    state_nxt    = STEP;
                    bkpt_hit_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = HALTING;
                if (bkpt_match) bkpt_hit_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= RST_STATE;
            bkpt_hit         <= 1'b0;
            cnt              <= '0;
            pc               <= '0;
            dbg.dbg_rdata    <= '0;
            dbg.dbg_rd_ready <= 1'b0;
            dbg.dbg_err      <= 1'b0;
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
`ifdef CORE_DBG_BKPT_EN
            bkpt             <= '0;
`endif
        end else begin
            state    <= state_nxt;
            bkpt_hit <= bkpt_hit_nxt;

            if (clr_cmd)                cnt <= '0;
            else if (core_retire_valid) cnt <= cnt + CNT_WIDTH'(1);
            if (core_retire_valid)      pc  <= core_retire_addr;

            dbg.dbg_rd_ready <= rd_req;
            dbg.dbg_err      <= acc_err;
            if (rd_req) dbg.dbg_rdata <= addr_bad ? '0 : rd_val;

            if (wr_req && !acc_err) begin
`ifdef CORE_DBG_BKPT_EN
                if (dbg.dbg_addr == A_BKPT) bkpt <= dbg.dbg_wdata;
`endif
                for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                    if (dbg.dbg_addr == REG_ADDR_WIDTH'(6 + i)) begin
                        for (int unsigned b = 0; b < STRB_W; b++) begin
                            if (dbg.dbg_wstrobe[b])
                                scratch[i][b*8 +: 8] <= dbg.dbg_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_core_dbg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_dbg_ctrl
// Directed self-checking bench for core_dbg_ctrl. A default-width instance
// (RST_HALT=1) covers the register map and state machine; a narrow instance
// (DATA_WIDTH=8, CNT_WIDTH=12) makes counter carry and wrap reachable.
// -----------------------------------------------------------------------------
module tb_core_dbg_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic        rst_n;
    logic        retire_valid;
    logic [29:0] retire_addr;
    logic [29:0] fetch_addr;
    logic        pipe_empty;
    logic        stall, halted;

    core_dbg_ctrl_if #(.REG_ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    core_dbg_ctrl #(.RST_HALT(1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dbg               (bus),
        .core_retire_valid (retire_valid),
        .core_retire_addr  (retire_addr),
        .core_fetch_addr   (fetch_addr),
        .core_pipe_empty   (pipe_empty),
        .core_stall        (stall),
        .core_halted       (halted)
    );

    logic       s_rst_n;
    logic       s_retire_valid;
    logic [5:0] s_retire_addr;
    logic       s_stall, s_halted;

    core_dbg_ctrl_if #(.REG_ADDR_WIDTH(5), .DATA_WIDTH(8)) sbus ();

    core_dbg_ctrl #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .NUM_SCRATCH (2),
        .CNT_WIDTH   (12)
    ) u_small (
        .clk               (clk),
        .rst_n             (s_rst_n),
        .dbg               (sbus),
        .core_retire_valid (s_retire_valid),
        .core_retire_addr  (s_retire_addr),
        .core_fetch_addr   (6'd0),
        .core_pipe_empty   (1'b1),
        .core_stall        (s_stall),
        .core_halted       (s_halted)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.dbg_req = 1'b1; bus.dbg_wr_rd = 1'b1;
        bus.dbg_addr = a; bus.dbg_wdata = d; bus.dbg_wstrobe = s;
        tick(1);
        bus.dbg_req = 1'b0; bus.dbg_wr_rd = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        bus.dbg_req = 1'b1; bus.dbg_wr_rd = 1'b0; bus.dbg_addr = a;
        tick(1);
        bus.dbg_req = 1'b0;
    endtask

    task automatic srd(input logic [4:0] a);
        sbus.dbg_req = 1'b1; sbus.dbg_wr_rd = 1'b0; sbus.dbg_addr = a;
        tick(1);
        sbus.dbg_req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s_rst_n = 1'b0; pipe_empty = 1'b1;
        tick(2);
        rst_n = 1'b1; s_rst_n = 1'b1;
        vectors++;
        if (stall !== 1'b1 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_stall_halted: got stall=%b halted=%b want 1 1", stall, halted);
        end
        vectors++;
        if (bus.dbg_rdata !== 32'h0 || bus.dbg_rd_ready !== 1'b0 || bus.dbg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_bus: got rdata=%h rdy=%b err=%b want 0 0 0",
                     bus.dbg_rdata, bus.dbg_rd_ready, bus.dbg_err);
        end
        rd(5'd1);
        vectors++;
        if (bus.dbg_rdata !== 32'h6 || bus.dbg_rd_ready !== 1'b1 || bus.dbg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got rdata=%h rdy=%b err=%b want 6 1 0",
                     bus.dbg_rdata, bus.dbg_rd_ready, bus.dbg_err);
        end
        tick(1);
        vectors++;
        if (bus.dbg_rd_ready !== 1'b0 || bus.dbg_rdata !== 32'h6) begin
            miscompares++;
            $display("FAIL rdy_pulse_hold: got rdy=%b rdata=%h want 0 6", bus.dbg_rd_ready, bus.dbg_rdata);
        end
    endtask

    task automatic test_resume;
        wr(5'd0, 32'h2, 4'h0);
        vectors++;
        if (stall !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_stall: got stall=%b halted=%b want 0 0", stall, halted);
        end
        rd(5'd1);
        vectors++;
        if (bus.dbg_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL resume_status: got %h want 0", bus.dbg_rdata);
        end
    endtask

    task automatic test_halt;
        pipe_empty = 1'b0;
        wr(5'd0, 32'h1, 4'h0);
        vectors++;
        if (stall !== 1'b1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halting_stall: got stall=%b halted=%b want 1 0", stall, halted);
        end
        for (int i = 0; i < 3; i++) begin
            rd(5'd1);
            vectors++;
            if (bus.dbg_rdata !== 32'h1) begin
                miscompares++;
                $display("FAIL halting_status[%0d]: got %h want 1", i, bus.dbg_rdata);
            end
        end
        pipe_empty = 1'b1;
        tick(1);
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halted_after_empty: got %b want 1", halted);
        end
    endtask

    task automatic test_step;
        pipe_empty = 1'b0;
        wr(5'd0, 32'h4, 4'h0);
        vectors++;
        if (stall !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL step_cycle: got stall=%b halted=%b want 0 0", stall, halted);
        end
        tick(1);
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL step_to_halting: got stall=%b want 1", stall);
        end
        rd(5'd1);
        vectors++;
        if (bus.dbg_rdata !== 32'h1) begin
            miscompares++;
            $display("FAIL step_halting_status: got %h want 1", bus.dbg_rdata);
        end
        pipe_empty = 1'b1;
        tick(1);
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL step_rehalted: got %b want 1", halted);
        end
        // HALT+RESUME while halted: RESUME wins
        wr(5'd0, 32'h3, 4'h0);
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_resume_halted: got stall=%b want 0", stall);
        end
        // STEP in RUN is ignored
        wr(5'd0, 32'h4, 4'h0);
        rd(5'd1);
        vectors++;
        if (bus.dbg_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL step_in_run: got %h want 0", bus.dbg_rdata);
        end
        // HALT+RESUME while running: HALT wins
        wr(5'd0, 32'h3, 4'h0);
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_resume_run: got stall=%b want 1", stall);
        end
        rd(5'd1);
        wr(5'd0, 32'h2, 4'h0);
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_again: got stall=%b want 0", stall);
        end
    endtask

    task automatic test_counter;
        for (int i = 0; i < 5; i++) begin
            retire_valid = 1'b1;
            retire_addr  = 30'((32'h40 + 32'(4 * i)) >> 2);
            tick(1);
        end
        retire_valid = 1'b0;
        rd(5'd3);
        vectors++;
        if (bus.dbg_rdata !== 32'd5) begin
            miscompares++;
            $display("FAIL cnt_lo_5: got %h want 5", bus.dbg_rdata);
        end
        rd(5'd2);
        vectors++;
        if (bus.dbg_rdata !== 32'h50) begin
            miscompares++;
            $display("FAIL pc_50: got %h want 50", bus.dbg_rdata);
        end
        rd(5'd4);
        vectors++;
        if (bus.dbg_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL cnt_hi_0: got %h want 0", bus.dbg_rdata);
        end
        // read in the same cycle as a retire sees the old PC
        retire_valid = 1'b1; retire_addr = 30'h18;
        rd(5'd2);
        retire_valid = 1'b0;
        vectors++;
        if (bus.dbg_rdata !== 32'h50) begin
            miscompares++;
            $display("FAIL pc_same_cycle: got %h want 50", bus.dbg_rdata);
        end
        rd(5'd2);
        vectors++;
        if (bus.dbg_rdata !== 32'h60) begin
            miscompares++;
            $display("FAIL pc_60: got %h want 60", bus.dbg_rdata);
        end
        rd(5'd3);
        vectors++;
        if (bus.dbg_rdata !== 32'd6) begin
            miscompares++;
            $display("FAIL cnt_lo_6: got %h want 6", bus.dbg_rdata);
        end
        // CNT_CLR together with a retire: clear wins
        retire_valid = 1'b1; retire_addr = 30'h1c;
        wr(5'd0, 32'h8, 4'h0);
        retire_valid = 1'b0;
        rd(5'd3);
        vectors++;
        if (bus.dbg_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL cnt_clr_wins: got %h want 0", bus.dbg_rdata);
        end
        rd(5'd2);
        vectors++;
        if (bus.dbg_rdata !== 32'h70) begin
            miscompares++;
            $display("FAIL pc_70: got %h want 70", bus.dbg_rdata);
        end
    endtask

    task automatic test_scratch;
        wr(5'd6, 32'hAABBCCDD, 4'hF);
        vectors++;
        if (bus.dbg_err !== 1'b0 || bus.dbg_rd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL scratch_wr_flags: got err=%b rdy=%b want 0 0", bus.dbg_err, bus.dbg_rd_ready);
        end
        wr(5'd6, 32'h11223344, 4'h5);
        rd(5'd6);
        vectors++;
        if (bus.dbg_rdata !== 32'hAA22CC44) begin
            miscompares++;
            $display("FAIL scratch_strobe: got %h want aa22cc44", bus.dbg_rdata);
        end
        wr(5'd13, 32'h12345678, 4'hF);
        rd(5'd13);
        vectors++;
        if (bus.dbg_rdata !== 32'h12345678 || bus.dbg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL scratch_last: got %h err=%b want 12345678 0", bus.dbg_rdata, bus.dbg_err);
        end
        wr(5'd7, 32'hFFFFFFFF, 4'h0);
        rd(5'd7);
        vectors++;
        if (bus.dbg_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL scratch_no_strobe: got %h want 0", bus.dbg_rdata);
        end
        rd(5'd13);
        rd(5'd31);
        vectors++;
        if (bus.dbg_rdata !== 32'h0 || bus.dbg_rd_ready !== 1'b1 || bus.dbg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_addr31: got rdata=%h rdy=%b err=%b want 0 1 1",
                     bus.dbg_rdata, bus.dbg_rd_ready, bus.dbg_err);
        end
        tick(1);
        vectors++;
        if (bus.dbg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse: got %b want 0", bus.dbg_err);
        end
        rd(5'd14);
        vectors++;
        if (bus.dbg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_addr14: got err=%b want 1", bus.dbg_err);
        end
        wr(5'd2, 32'hFFFFFFFF, 4'hF);
        vectors++;
        if (bus.dbg_err !== 1'b1 || bus.dbg_rd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_pc_err: got err=%b rdy=%b want 1 0", bus.dbg_err, bus.dbg_rd_ready);
        end
        rd(5'd2);
        vectors++;
        if (bus.dbg_rdata !== 32'h70 || bus.dbg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL pc_unchanged: got %h err=%b want 70 0", bus.dbg_rdata, bus.dbg_err);
        end
        rd(5'd0);
        vectors++;
        if (bus.dbg_rdata !== 32'h0 || bus.dbg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ctrl_reads_0: got %h err=%b want 0 0", bus.dbg_rdata, bus.dbg_err);
        end
    endtask

    task automatic test_bkpt;
`ifdef CORE_DBG_BKPT_EN
        wr(5'd5, 32'h101, 4'hF);
        vectors++;
        if (bus.dbg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bkpt_wr_err: got %b want 0", bus.dbg_err);
        end
        rd(5'd5);
        vectors++;
        if (bus.dbg_rdata !== 32'h101) begin
            miscompares++;
            $display("FAIL bkpt_readback: got %h want 101", bus.dbg_rdata);
        end
        pipe_empty = 1'b0;
        fetch_addr = 30'h40;
        tick(1);
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL bkpt_halting: got stall=%b want 1", stall);
        end
        rd(5'd1);
        vectors++;
        if (bus.dbg_rdata !== 32'h9) begin
            miscompares++;
            $display("FAIL bkpt_status: got %h want 9", bus.dbg_rdata);
        end
        fetch_addr = 30'h0;
        pipe_empty = 1'b1;
        tick(1);
        rd(5'd1);
        vectors++;
        if (bus.dbg_rdata !== 32'hE) begin
            miscompares++;
            $display("FAIL bkpt_halted_status: got %h want e", bus.dbg_rdata);
        end
        wr(5'd0, 32'h2, 4'h0);
        rd(5'd1);
        vectors++;
        if (bus.dbg_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL bkpt_resume_clears: got %h want 0", bus.dbg_rdata);
        end
`else
        wr(5'd5, 32'h101, 4'hF);
        vectors++;
        if (bus.dbg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bkpt_wr_err: got %b want 1", bus.dbg_err);
        end
        rd(5'd5);
        vectors++;
        if (bus.dbg_rdata !== 32'h0 || bus.dbg_err !== 1'b0 || bus.dbg_rd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bkpt_reads_0: got rdata=%h err=%b rdy=%b want 0 0 1",
                     bus.dbg_rdata, bus.dbg_err, bus.dbg_rd_ready);
        end
        fetch_addr = 30'h40;
        tick(2);
        rd(5'd1);
        fetch_addr = 30'h0;
        vectors++;
        if (bus.dbg_rdata !== 32'h0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL bkpt_disabled: got status=%h stall=%b want 0 0", bus.dbg_rdata, stall);
        end
`endif
    endtask

    task automatic test_reset_mid;
        retire_valid = 1'b1; retire_addr = 30'h3;
        tick(1);
        retire_valid = 1'b0;
        bus.dbg_req = 1'b1; bus.dbg_wr_rd = 1'b0; bus.dbg_addr = 5'd6;
        rst_n = 1'b0;
        tick(1);
        bus.dbg_req = 1'b0;
        rst_n = 1'b1;
        vectors++;
        if (bus.dbg_rd_ready !== 1'b0 || bus.dbg_rdata !== 32'h0 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: got rdy=%b rdata=%h stall=%b want 0 0 1",
                     bus.dbg_rd_ready, bus.dbg_rdata, stall);
        end
        rd(5'd3);
        vectors++;
        if (bus.dbg_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_cnt: got %h want 0", bus.dbg_rdata);
        end
        rd(5'd6);
        vectors++;
        if (bus.dbg_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_scratch: got %h want 0", bus.dbg_rdata);
        end
    endtask

    task automatic test_cnt_wrap;
        s_retire_valid = 1'b1;
        tick(255);
        s_retire_valid = 1'b0;
        srd(5'd3);
        vectors++;
        if (sbus.dbg_rdata !== 8'hFF) begin
            miscompares++;
            $display("FAIL small_lo_ff: got %h want ff", sbus.dbg_rdata);
        end
        s_retire_valid = 1'b1;
        tick(1);
        s_retire_valid = 1'b0;
        srd(5'd3);
        vectors++;
        if (sbus.dbg_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL small_lo_carry: got %h want 0", sbus.dbg_rdata);
        end
        srd(5'd4);
        vectors++;
        if (sbus.dbg_rdata !== 8'h01) begin
            miscompares++;
            $display("FAIL small_hi_carry: got %h want 1", sbus.dbg_rdata);
        end
        s_retire_valid = 1'b1;
        tick(4096 - 256);
        s_retire_valid = 1'b0;
        srd(5'd4);
        vectors++;
        if (sbus.dbg_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL small_wrap_hi: got %h want 0", sbus.dbg_rdata);
        end
        srd(5'd3);
        vectors++;
        if (sbus.dbg_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL small_wrap_lo: got %h want 0", sbus.dbg_rdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; s_rst_n = 1'b0;
        retire_valid = 1'b0; retire_addr = '0; fetch_addr = '0; pipe_empty = 1'b1;
        s_retire_valid = 1'b0; s_retire_addr = 6'h2A;
        bus.dbg_req = 1'b0; bus.dbg_wr_rd = 1'b0; bus.dbg_addr = '0;
        bus.dbg_wdata = '0; bus.dbg_wstrobe = '0;
        sbus.dbg_req = 1'b0; sbus.dbg_wr_rd = 1'b0; sbus.dbg_addr = '0;
        sbus.dbg_wdata = '0; sbus.dbg_wstrobe = '0;
        #1;
        test_reset;
        test_resume;
        test_halt;
        test_step;
        test_counter;
        test_scratch;
        test_bkpt;
        test_reset_mid;
        test_cnt_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
